// File: rtl/alu_result_stage.sv
// Registered result-select stage between the ALU and register writeback.
// A main + skid entry pair gives full throughput with a registered in_ready.
module alu_result_stage #(
  parameter int COUNT_EN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [2:0]  br_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] alu_add_sub,
  input  logic [31:0] alu_shl,
  input  logic [31:0] alu_shr,
  input  logic        alu_eq,
  input  logic        alu_ltu,
  input  logic        alu_lts,
  input  logic [31:0] reg_op1,
  input  logic [31:0] reg_op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_branch_taken,
  output logic        out_illegal,
  output logic [31:0] out_count
);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        taken;
    logic        illegal;
  } entry_t;

  entry_t nxt, main_q, skid_q;
  logic   main_v, skid_v;
  logic   accept, xfer;

  assign accept = in_valid && !skid_v;
  assign xfer   = main_v && out_ready;

  // Result is resolved at accept time so the buffer only stores finished entries.
  always_comb begin
    nxt    = '0;
    nxt.rd = in_rd;
    case (op_sel)
      4'd0: nxt.data = alu_add_sub;
      4'd1: nxt.data = alu_shl;
      4'd2: nxt.data = alu_shr;
      4'd3: nxt.data = {31'b0, alu_lts};
      4'd4: nxt.data = {31'b0, alu_ltu};
      4'd5: nxt.data = reg_op1 ^ reg_op2;
      4'd6: nxt.data = reg_op1 | reg_op2;
      4'd7: nxt.data = reg_op1 & reg_op2;
      4'd8: begin
        case (br_funct3)
          3'b000:  nxt.taken = alu_eq;
          3'b001:  nxt.taken = !alu_eq;
          3'b100:  nxt.taken = alu_lts;
          3'b101:  nxt.taken = !alu_lts;
          3'b110:  nxt.taken = alu_ltu;
          3'b111:  nxt.taken = !alu_ltu;
          default: nxt.illegal = 1'b1;
        endcase
      end
      4'd9:    nxt.data = reg_op2;
      default: nxt.illegal = 1'b1;
    endcase
    nxt.wen = (op_sel <= 4'd9) && (op_sel != 4'd8) && (in_rd != 5'd0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (!main_v) begin
      if (accept) begin
        main_q <= nxt;
        main_v <= 1'b1;
      end
    end else if (!skid_v) begin
      if (accept && xfer) begin
        main_q <= nxt;
      end else if (accept) begin
        skid_q <= nxt;
        skid_v <= 1'b1;
      end else if (xfer) begin
        main_v <= 1'b0;
      end
    end else if (xfer) begin
      main_q <= skid_q;
      skid_v <= 1'b0;
    end
  end

  assign in_ready         = !skid_v;
  assign out_valid        = main_v;
  assign out_data         = main_q.data;
  assign out_rd           = main_q.rd;
  assign out_wen          = main_q.wen;
  assign out_branch_taken = main_q.taken;
  assign out_illegal      = main_q.illegal;

  generate
    if (COUNT_EN != 0) begin : g_cnt
      logic [31:0] cnt_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   cnt_q <= '0;
        else if (xfer) cnt_q <= cnt_q + 32'd1;
      end
      assign out_count = cnt_q;
    end else begin : g_nocnt
      assign out_count = '0;
    end
  endgenerate

endmodule
